uart_tx_fsm: RTL and testbench
==============================

// Module: uart_tx_fsm
// PURPOSE
//  Control FSM of the UART transmitter. Sequences one frame per accepted DATA_VALID:
//  start bit, data bits (serializer enabled), optional parity bit, stop bit(s).
//  Drives the serializer enable, the TX output mux select and the BUSY status.
//  Sits between the parallel input interface and the serializer/parity/mux datapath.
// PARAMETERS
//  STOP_BITS  1  number of stop-bit cycles per frame; legal values 1 or 2
// PORTS
//  CLK         in   1  single clock; all state changes on rising edge
//  RST         in   1  synchronous, active-high reset
//  PAR_EN      in   1  1 = append parity bit to frame; sampled on frame acceptance
//  DATA_VALID  in   1  request to send a frame; accepted only when idle
//  ser_done    in   1  serializer: last data bit is being shifted this cycle
//  ser_en      out  1  serializer shift enable
//  mux_sel     out  2  TX mux select: 00 start(0), 01 stop/idle(1), 10 serial data, 11 parity
//  BUSY        out  1  high while a frame is in progress
// BEHAVIOUR
//  - States: IDLE, START, DATA, PARITY, STOP. One-hot or binary encoding is free.
//  - Outputs are Moore, decoded combinationally from the state register:
//      IDLE:   ser_en=0 mux_sel=01 BUSY=0
//      START:  ser_en=0 mux_sel=00 BUSY=1
//      DATA:   ser_en=1 mux_sel=10 BUSY=1
//      PARITY: ser_en=0 mux_sel=11 BUSY=1
//      STOP:   ser_en=0 mux_sel=01 BUSY=1
//  - Reset: RST=1 at a clock edge -> state IDLE, par_en latch 0, stop counter 0;
//    outputs therefore take IDLE values the cycle after reset. Reset mid-frame aborts
//    the frame immediately (no stop bit emitted).
//  - IDLE -> START when DATA_VALID=1; PAR_EN latched into internal par_en_q at this edge.
//    DATA_VALID=0 keeps IDLE. DATA_VALID while not IDLE is ignored (no queueing).
//  - START -> DATA unconditionally after exactly 1 cycle.
//  - DATA stays while ser_done=0; on ser_done=1 -> PARITY if par_en_q=1 else STOP.
//    ser_done ignored in every state other than DATA.
//  - PARITY -> STOP after exactly 1 cycle.
//  - STOP lasts STOP_BITS cycles (counter cleared on STOP entry), then -> IDLE.
//  - PAR_EN changes mid-frame have no effect on the current frame.
//  - Latency: DATA_VALID sampled at edge N -> BUSY=1, mux_sel=00 during cycle N+1.
//  - Frame length (cycles with BUSY=1) = 1 + data cycles + par_en_q + STOP_BITS.
// CONFIGURATION
//  Macro UART_TX_B2B_EN:
//   defined   - on the last STOP cycle, if DATA_VALID=1, go directly to START (PAR_EN
//               re-latched); BUSY stays 1 with no IDLE gap between frames.
//   undefined - last STOP cycle always returns to IDLE; at least one IDLE cycle
//               (BUSY=0, mux_sel=01) between frames.
// TESTING
//  1. RST=1 two edges, other inputs 0 -> BUSY=0, ser_en=0, mux_sel=01; stays IDLE after RST=0.
//  2. RST=0, PAR_EN=1, DATA_VALID=1, ser_done=1 held, STOP_BITS=1, macro off ->
//     mux_sel per cycle 00,10,11,01,01(idle),00,... ; BUSY 1,1,1,1,0,1; ser_en 0,1,0,0,0,0.
//  3. Same as 2 with macro on -> mux_sel repeats 00,10,11,01 with BUSY continuously 1.
//  4. PAR_EN=0, DATA_VALID pulsed 1 cycle, ser_done high on 8th DATA cycle ->
//     START 1, DATA 8 cycles (ser_en=1), STOP 1, IDLE; no mux_sel=11 ever.
//  5. PAR_EN toggled and DATA_VALID pulsed during DATA -> frame unchanged, no second frame.
//  6. RST=1 during DATA -> next cycle IDLE outputs; STOP_BITS=2 run shows two 01 BUSY cycles.

Source files
------------

// File: rtl/uart_tx_fsm.sv
// UART transmitter control FSM: sequences start, data, optional parity and stop bits.
// Build option UART_TX_B2B_EN: when defined, a request on the last stop cycle chains the next frame with no idle gap.
module uart_tx_fsm #(
    parameter int STOP_BITS = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PAR_EN,
    input  logic       DATA_VALID,
    input  logic       ser_done,
    output logic       ser_en,
    output logic [1:0] mux_sel,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       par_en_q;
    logic [1:0] stop_cnt;
    logic       stop_last;
    logic       chain_go;
    logic       accept;

    assign stop_last = (stop_cnt == 2'(STOP_BITS - 1));

`ifdef UART_TX_B2B_EN
    assign chain_go = (state == S_STOP) && stop_last && DATA_VALID;
`else
    assign chain_go = 1'b0;
`endif

    assign accept = ((state == S_IDLE) && DATA_VALID) || chain_go;

    // State register, parity latch and stop-bit counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            par_en_q <= 1'b0;
            stop_cnt <= 2'd0;
        end else begin
            state <= state_nxt;
            if (accept)
                par_en_q <= PAR_EN;
            // Held at zero outside STOP so every STOP entry starts counting from 0
            if (state != S_STOP)
                stop_cnt <= 2'd0;
            else if (!stop_last)
                stop_cnt <= stop_cnt + 2'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (DATA_VALID) state_nxt = S_START;
            S_START:  state_nxt = S_DATA;
            S_DATA:   if (ser_done) state_nxt = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: state_nxt = S_STOP;
            S_STOP:   if (stop_last) state_nxt = chain_go ? S_START : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ser_en  = 1'b0;
        mux_sel = 2'b01;
        BUSY    = 1'b0;
        case (state)
            S_START: begin
                mux_sel = 2'b00;
                BUSY    = 1'b1;
            end
            S_DATA: begin
                ser_en  = 1'b1;
                mux_sel = 2'b10;
                BUSY    = 1'b1;
            end
            S_PARITY: begin
                mux_sel = 2'b11;
                BUSY    = 1'b1;
            end
            S_STOP: begin
                mux_sel = 2'b01;
                BUSY    = 1'b1;
            end
            default: begin
                ser_en  = 1'b0;
                mux_sel = 2'b01;
                BUSY    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: two instances (1 and 2 stop bits) checked against a frame-position reference model.
module tb_uart_tx_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       pen;
    logic       dv;
    logic       sd     [2];
    logic       sen_o  [2];
    logic [1:0] mux_o  [2];
    logic       busy_o [2];

    int checks   = 0;
    int failures = 0;

    // Reference model: each frame is a run of cycles indexed by pos
    // (0 = start, 1..k = data, k+1 = parity if enabled, then stop bits).
    bit act  [2];
    int pos  [2];
    int kk   [2];
    bit par  [2];
    int sb   [2];
    int force_k;

    always #5 clk = ~clk;

    uart_tx_fsm #(.STOP_BITS(1)) dut0 (
        .CLK(clk), .RST(rst), .PAR_EN(pen), .DATA_VALID(dv), .ser_done(sd[0]),
        .ser_en(sen_o[0]), .mux_sel(mux_o[0]), .BUSY(busy_o[0])
    );

    uart_tx_fsm #(.STOP_BITS(2)) dut1 (
        .CLK(clk), .RST(rst), .PAR_EN(pen), .DATA_VALID(dv), .ser_done(sd[1]),
        .ser_en(sen_o[1]), .mux_sel(mux_o[1]), .BUSY(busy_o[1])
    );

    function automatic logic [1:0] exp_mux(int d);
        if (!act[d])                         return 2'b01;
        if (pos[d] == 0)                     return 2'b00;
        if (pos[d] <= kk[d])                 return 2'b10;
        if (par[d] && pos[d] == kk[d] + 1)   return 2'b11;
        return 2'b01;
    endfunction

    function automatic logic exp_busy(int d);
        return act[d];
    endfunction

    function automatic logic exp_sen(int d);
        return act[d] && pos[d] >= 1 && pos[d] <= kk[d];
    endfunction

    task automatic start_frame(int d);
        act[d] = 1'b1;
        pos[d] = 0;
        kk[d]  = (force_k > 0) ? force_k : $urandom_range(1, 6);
        par[d] = pen;
    endtask

    // Drive ser_done from the model, clock once, advance the model, settle 1 ns.
    task automatic tick();
        for (int d = 0; d < 2; d++) begin
            if (act[d] && pos[d] >= 1 && pos[d] <= kk[d])
                sd[d] = (pos[d] == kk[d]);
            else
                sd[d] = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                act[d] = 1'b0;
            end else if (!act[d]) begin
                if (dv) start_frame(d);
            end else if (pos[d] == kk[d] + int'(par[d]) + sb[d]) begin
                act[d] = 1'b0;
`ifdef UART_TX_B2B_EN
                if (dv) start_frame(d);
`endif
            end else begin
                pos[d] = pos[d] + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; dv = 1'b0; pen = 1'b0; force_k = 0;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy_o[d], mux_o[d], sen_o[d]} !== 4'b0_01_0) begin
                failures++;
                $display("FAIL reset_state dut%0d got busy=%b mux=%b ser_en=%b want busy=0 mux=01 ser_en=0",
                         d, busy_o[d], mux_o[d], sen_o[d]);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({busy_o[d], mux_o[d], sen_o[d]} !== 4'b0_01_0) begin
                    failures++;
                    $display("FAIL idle_hold dut%0d cyc%0d got busy=%b mux=%b ser_en=%b want busy=0 mux=01 ser_en=0",
                             d, c, busy_o[d], mux_o[d], sen_o[d]);
                end
            end
        end
    endtask

    task automatic test_parity_stream();
        int idle_seen = 0;
        pen = 1'b1; dv = 1'b1; force_k = 1;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (!busy_o[0]) idle_seen++;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({busy_o[d], mux_o[d], sen_o[d]} !== {exp_busy(d), exp_mux(d), exp_sen(d)}) begin
                    failures++;
                    $display("FAIL parity_stream dut%0d cyc%0d got busy=%b mux=%b ser_en=%b want busy=%b mux=%b ser_en=%b",
                             d, c, busy_o[d], mux_o[d], sen_o[d], exp_busy(d), exp_mux(d), exp_sen(d));
                end
            end
        end
        checks++;
`ifdef UART_TX_B2B_EN
        if (idle_seen != 0) begin
            failures++;
            $display("FAIL b2b_gap idle_cycles got %0d want 0", idle_seen);
        end
`else
        if (idle_seen < 3) begin
            failures++;
            $display("FAIL frame_gap idle_cycles got %0d want >=3", idle_seen);
        end
`endif
        dv = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy_o[d] !== 1'b0) begin
                failures++;
                $display("FAIL stream_drain dut%0d busy got %b want 0", d, busy_o[d]);
            end
        end
    endtask

    task automatic test_no_parity();
        int sen_cnt = 0, busy_cnt = 0, par_cnt = 0, stop1 = 0;
        pen = 1'b0; force_k = 8;
        for (int c = 0; c < 16; c++) begin
            dv = (c == 0);
            tick();
            if (sen_o[0]) sen_cnt++;
            if (busy_o[0]) busy_cnt++;
            if (mux_o[0] == 2'b11 || mux_o[1] == 2'b11) par_cnt++;
            if (busy_o[1] && mux_o[1] == 2'b01) stop1++;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({busy_o[d], mux_o[d], sen_o[d]} !== {exp_busy(d), exp_mux(d), exp_sen(d)}) begin
                    failures++;
                    $display("FAIL no_parity dut%0d cyc%0d got busy=%b mux=%b ser_en=%b want busy=%b mux=%b ser_en=%b",
                             d, c, busy_o[d], mux_o[d], sen_o[d], exp_busy(d), exp_mux(d), exp_sen(d));
                end
            end
        end
        checks++;
        if (sen_cnt != 8 || busy_cnt != 10 || par_cnt != 0 || stop1 != 2) begin
            failures++;
            $display("FAIL no_parity_counts got ser_en=%0d busy=%0d parity=%0d stop2=%0d want 8 10 0 2",
                     sen_cnt, busy_cnt, par_cnt, stop1);
        end
    endtask

    task automatic test_midframe();
        int busy_cnt = 0;
        force_k = 5;
        for (int c = 0; c < 17; c++) begin
            pen = (c == 3) ? 1'b0 : 1'b1;
            dv  = (c == 0 || c == 3);
            tick();
            if (busy_o[1]) busy_cnt++;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({busy_o[d], mux_o[d], sen_o[d]} !== {exp_busy(d), exp_mux(d), exp_sen(d)}) begin
                    failures++;
                    $display("FAIL midframe dut%0d cyc%0d got busy=%b mux=%b ser_en=%b want busy=%b mux=%b ser_en=%b",
                             d, c, busy_o[d], mux_o[d], sen_o[d], exp_busy(d), exp_mux(d), exp_sen(d));
                end
            end
        end
        checks++;
        if (busy_cnt != 9) begin
            failures++;
            $display("FAIL midframe_len dut1 busy cycles got %0d want 9", busy_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        pen = 1'b1; force_k = 6;
        dv = 1'b1; tick();
        dv = 1'b0; tick(); tick();
        rst = 1'b1; tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy_o[d], mux_o[d], sen_o[d]} !== 4'b0_01_0) begin
                failures++;
                $display("FAIL reset_midframe dut%0d got busy=%b mux=%b ser_en=%b want busy=0 mux=01 ser_en=0",
                         d, busy_o[d], mux_o[d], sen_o[d]);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (busy_o[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL post_abort dut%0d cyc%0d busy got %b want 0", d, c, busy_o[d]);
                end
            end
        end
    endtask

    task automatic test_random();
        force_k = 0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            dv  = ($urandom_range(0, 9) < 3);
            pen = 1'($urandom_range(0, 1));
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({busy_o[d], mux_o[d], sen_o[d]} !== {exp_busy(d), exp_mux(d), exp_sen(d)}) begin
                    failures++;
                    $display("FAIL random dut%0d cyc%0d got busy=%b mux=%b ser_en=%b want busy=%b mux=%b ser_en=%b",
                             d, c, busy_o[d], mux_o[d], sen_o[d], exp_busy(d), exp_mux(d), exp_sen(d));
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        sb[0] = 1; sb[1] = 2;
        act[0] = 1'b0; act[1] = 1'b0;
        pos[0] = 0; pos[1] = 0;
        kk[0] = 1; kk[1] = 1;
        par[0] = 1'b0; par[1] = 1'b0;
        sd[0] = 1'b0; sd[1] = 1'b0;
        rst = 1'b1; dv = 1'b0; pen = 1'b0; force_k = 0;
        test_reset();
        test_parity_stream();
        test_no_parity();
        test_midframe();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
